// File: rtl/sobel_gcd_pkg.sv
// Shared types and constants for the GCD / Sobel command scheduler.
package sobel_gcd_pkg;

    typedef enum logic [1:0] {
        NOP     = 2'b00,
        GCD     = 2'b01,
        PIXEL   = 2'b10,
        CLR_ERR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GCD_RUN = 2'b01,
        PX_RUN  = 2'b10,
        RESP    = 2'b11
    } sched_state_e;

    // Engine bit of rsp_kind_o
    localparam logic RSP_ENG_GCD   = 1'b0;
    localparam logic RSP_ENG_SOBEL = 1'b1;

endpackage

// File: rtl/sobel_gcd_timeout_counter.sv
// Run-time guard: counts enabled cycles and flags the last permitted one.
module sobel_gcd_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, otherwise count while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire on the TIMEOUT_CYCLES-th enabled cycle after a clear
    assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/sobel_gcd_scheduler.sv
// Sequences the GCD core and the Sobel pixel pipeline from one command
// stream; one tagged response per GCD/PIXEL command, with a run-time guard.
module sobel_gcd_scheduler
    import sobel_gcd_pkg::*;
#(
    parameter int unsigned GCD_WIDTH      = 16,
    parameter int unsigned PX_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [2*GCD_WIDTH-1:0] cmd_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_kind_o,
    output logic [GCD_WIDTH-1:0]   rsp_data_o,
    output logic [GCD_WIDTH-1:0]   operand_a_o,
    output logic [GCD_WIDTH-1:0]   operand_b_o,
    output logic                   gcd_enable_o,
    input  logic [GCD_WIDTH-1:0]   gcd_i,
    input  logic                   gcd_done_i,
    output logic                   prep_allowed_o,
    output logic [PX_WIDTH-1:0]    input_px_gray_o,
    input  logic [PX_WIDTH-1:0]    output_px_sobel_i,
    input  logic                   pixel_completed_i,
    input  logic                   prep_completed_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    sched_state_e           state_q, state_d;
    logic [GCD_WIDTH-1:0]   operand_a_q, operand_a_d;
    logic [GCD_WIDTH-1:0]   operand_b_q, operand_b_d;
    logic [PX_WIDTH-1:0]    px_gray_q, px_gray_d;
    logic [1:0]             rsp_kind_q, rsp_kind_d;
    logic [GCD_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                   timeout_q, timeout_d;

    cmd_op_e cmd_op;
    logic    timer_clear;
    logic    timer_run;
    logic    timer_expire;

    assign cmd_op    = cmd_op_e'(cmd_op_i);
    assign timer_run = (state_q == GCD_RUN) || (state_q == PX_RUN);

    sobel_gcd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (timer_clear),
        .enable_i(timer_run),
        .expire_o(timer_expire)
    );

    // Next-state, operand capture and response capture
    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        px_gray_d   = px_gray_q;
        rsp_kind_d  = rsp_kind_q;
        rsp_data_d  = rsp_data_q;
        timeout_d   = timeout_q;
        timer_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    unique case (cmd_op)
                        GCD: begin
                            operand_a_d = cmd_data_i[2*GCD_WIDTH-1:GCD_WIDTH];
                            operand_b_d = cmd_data_i[GCD_WIDTH-1:0];
                            timer_clear = 1'b1;
                            state_d     = GCD_RUN;
                        end
                        PIXEL: begin
                            px_gray_d   = cmd_data_i[PX_WIDTH-1:0];
                            timer_clear = 1'b1;
                            state_d     = PX_RUN;
                        end
                        CLR_ERR: timeout_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            GCD_RUN: begin
                // Completion takes priority over a simultaneous expiry
                if (gcd_done_i) begin
                    rsp_kind_d = {RSP_ENG_GCD, 1'b1};
                    rsp_data_d = gcd_i;
                    state_d    = RESP;
                end else if (timer_expire) begin
                    rsp_kind_d = {RSP_ENG_GCD, 1'b0};
                    rsp_data_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            PX_RUN: begin
                if (pixel_completed_i) begin
                    rsp_kind_d = {RSP_ENG_SOBEL, prep_completed_i};
                    rsp_data_d = prep_completed_i ? GCD_WIDTH'(output_px_sobel_i) : '0;
                    state_d    = RESP;
                end else if (timer_expire) begin
                    rsp_kind_d = {RSP_ENG_SOBEL, 1'b0};
                    rsp_data_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            operand_a_q <= '0;
            operand_b_q <= '0;
            px_gray_q   <= '0;
            rsp_kind_q  <= '0;
            rsp_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            px_gray_q   <= px_gray_d;
            rsp_kind_q  <= rsp_kind_d;
            rsp_data_q  <= rsp_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign gcd_enable_o    = (state_q == GCD_RUN);
    assign prep_allowed_o  = (state_q == PX_RUN);
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_kind_o      = rsp_kind_q;
    assign rsp_data_o      = rsp_data_q;
    assign operand_a_o     = operand_a_q;
    assign operand_b_o     = operand_b_q;
    assign input_px_gray_o = px_gray_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_sobel_gcd_scheduler.sv
// Self-checking bench for sobel_gcd_scheduler with a behavioural engine model.
module tb_sobel_gcd_scheduler;

    localparam int GW = 16;
    localparam int PW = 8;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = 2'b00;
    logic [2*GW-1:0] cmd_data_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [1:0]    rsp_kind_o;
    logic [GW-1:0] rsp_data_o;
    logic [GW-1:0] operand_a_o;
    logic [GW-1:0] operand_b_o;
    logic          gcd_enable_o;
    logic [GW-1:0] gcd_i = '0;
    logic          gcd_done_i = 1'b0;
    logic          prep_allowed_o;
    logic [PW-1:0] input_px_gray_o;
    logic [PW-1:0] output_px_sobel_i = '0;
    logic          pixel_completed_i = 1'b0;
    logic          prep_completed_i = 1'b0;
    logic          busy_o;
    logic          timeout_o;

    int n_vec = 0;
    int n_err = 0;
    bit tm_model = 1'b0;

    always #5 clk_i = ~clk_i;

    sobel_gcd_scheduler #(
        .GCD_WIDTH(GW),
        .PX_WIDTH(PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_kind_o(rsp_kind_o), .rsp_data_o(rsp_data_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .gcd_enable_o(gcd_enable_o), .gcd_i(gcd_i), .gcd_done_i(gcd_done_i),
        .prep_allowed_o(prep_allowed_o), .input_px_gray_o(input_px_gray_o),
        .output_px_sobel_i(output_px_sobel_i), .pixel_completed_i(pixel_completed_i),
        .prep_completed_i(prep_completed_i), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    function automatic logic [GW-1:0] ref_gcd(input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic [GW-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one command, play the engine (done at run cycle lat), stall the
    // consumer for `stall` cycles, then take the response. Observations only.
    task automatic drive_job(
        input  logic [1:0]    op,
        input  logic [2*GW-1:0] data,
        input  int            lat,
        input  logic          primed,
        input  logic [PW-1:0] sobel,
        input  logic [GW-1:0] gres,
        input  int            stall,
        output int            run_cyc,
        output bit            got_rsp,
        output logic [1:0]    kind,
        output logic [GW-1:0] rdata,
        output logic [GW-1:0] opa,
        output logic [GW-1:0] opb,
        output logic [PW-1:0] pxo,
        output bit            stable,
        output bit            ready_after
    );
        bit hit;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = data;
        tick();
        cmd_valid_i = 1'b0; cmd_data_i = $urandom;
        opa = operand_a_o; opb = operand_b_o; pxo = input_px_gray_o;
        run_cyc = 0;
        for (int k = 1; k <= 40 && !rsp_valid_o; k++) begin
            if (gcd_enable_o || prep_allowed_o) run_cyc++;
            hit = (k == lat);
            if (op == 2'b01) begin
                gcd_done_i        = hit;
                gcd_i             = hit ? gres : GW'($urandom);
                pixel_completed_i = ($urandom_range(0, 3) == 0);
                prep_completed_i  = 1'($urandom);
                output_px_sobel_i = PW'($urandom);
            end else begin
                pixel_completed_i = hit;
                prep_completed_i  = hit ? primed : 1'($urandom);
                output_px_sobel_i = hit ? sobel : PW'($urandom);
                gcd_done_i        = ($urandom_range(0, 3) == 0);
                gcd_i             = GW'($urandom);
            end
            tick();
        end
        gcd_done_i = 1'b0; pixel_completed_i = 1'b0;
        got_rsp = rsp_valid_o;
        kind = rsp_kind_o; rdata = rsp_data_o;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_data_i = $urandom;
            gcd_done_i = 1'($urandom); pixel_completed_i = 1'($urandom);
            tick();
            if (rsp_valid_o !== 1'b1 || rsp_kind_o !== kind || rsp_data_o !== rdata
                || cmd_ready_o !== 1'b0) stable = 1'b0;
        end
        cmd_valid_i = 1'b0; gcd_done_i = 1'b0; pixel_completed_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        ready_after = (cmd_ready_o === 1'b1) && (rsp_valid_o === 1'b0) && (busy_o === 1'b0);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        n_vec++;
        if ({cmd_ready_o, rsp_valid_o, rsp_kind_o, gcd_enable_o, prep_allowed_o, busy_o, timeout_o} !== 8'b1000_0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected %b",
                {cmd_ready_o, rsp_valid_o, rsp_kind_o, gcd_enable_o, prep_allowed_o, busy_o, timeout_o}, 8'b1000_0000);
        end
        n_vec++;
        if ({rsp_data_o, operand_a_o, operand_b_o, input_px_gray_o} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0",
                {rsp_data_o, operand_a_o, operand_b_o, input_px_gray_o});
        end
        reset_i = 1'b0;
        tm_model = 1'b0;
    endtask

    task automatic test_gcd_directed();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        drive_job(2'b01, {16'd48, 16'd18}, 5, 1'b0, '0, ref_gcd(16'd48, 16'd18), 0,
                  rc, gr, k, d, a, b, p, st, ra);
        n_vec++;
        if (rc !== 5) begin n_err++; $display("FAIL gcd_enable_cycles: got %0d expected 5", rc); end
        n_vec++;
        if (!gr || k !== 2'b01 || d !== 16'd6) begin
            n_err++; $display("FAIL gcd_48_18: got valid=%0d kind=%b data=%0d expected kind=01 data=6", gr, k, d);
        end
        n_vec++;
        if (a !== 16'd48 || b !== 16'd18) begin
            n_err++; $display("FAIL gcd_operands: got %0d,%0d expected 48,18", a, b);
        end
        n_vec++;
        if (!ra) begin n_err++; $display("FAIL gcd_ready_after: got 0 expected 1"); end
    endtask

    task automatic test_pixel_directed();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        drive_job(2'b10, 32'hABCD_1280, 3, 1'b0, 8'h55, '0, 0, rc, gr, k, d, a, b, p, st, ra);
        n_vec++;
        if (!gr || k !== 2'b10 || d !== 16'h0000 || p !== 8'h80) begin
            n_err++; $display("FAIL px_unprimed: got kind=%b data=%h px=%h expected kind=10 data=0000 px=80", k, d, p);
        end
        drive_job(2'b10, 32'h0000_0042, 2, 1'b1, 8'h3C, '0, 0, rc, gr, k, d, a, b, p, st, ra);
        n_vec++;
        if (!gr || k !== 2'b11 || d !== 16'h003C || rc !== 2) begin
            n_err++; $display("FAIL px_primed: got kind=%b data=%h run=%0d expected kind=11 data=003c run=2", k, d, rc);
        end
    endtask

    task automatic test_rsp_stall();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        drive_job(2'b01, {16'd91, 16'd35}, 4, 1'b0, '0, ref_gcd(16'd91, 16'd35), 10,
                  rc, gr, k, d, a, b, p, st, ra);
        n_vec++;
        if (!st || k !== 2'b01 || d !== 16'd7) begin
            n_err++; $display("FAIL rsp_stall: got stable=%0d kind=%b data=%0d expected stable=1 kind=01 data=7", st, k, d);
        end
        n_vec++;
        if (!ra) begin n_err++; $display("FAIL stall_release: got 0 expected 1"); end
    endtask

    task automatic test_timeout_clr();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        drive_job(2'b01, {16'd100, 16'd75}, 1000, 1'b0, '0, 16'd25, 2, rc, gr, k, d, a, b, p, st, ra);
        tm_model = 1'b1;
        n_vec++;
        if (!gr || rc !== TO || k !== 2'b00 || d !== '0) begin
            n_err++; $display("FAIL gcd_timeout: got run=%0d kind=%b data=%h expected run=%0d kind=00 data=0000", rc, k, d, TO);
        end
        n_vec++;
        if (timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b expected 1", timeout_o); end
        cmd_valid_i = 1'b1; cmd_op_i = 2'b11;
        tick();
        cmd_valid_i = 1'b0;
        tm_model = 1'b0;
        n_vec++;
        if (timeout_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL clr_err: got timeout=%b ready=%b expected timeout=0 ready=1", timeout_o, cmd_ready_o);
        end
        // Completion on the very last permitted cycle beats the expiry
        drive_job(2'b01, {16'd12, 16'd8}, TO, 1'b0, '0, 16'd4, 0, rc, gr, k, d, a, b, p, st, ra);
        n_vec++;
        if (k !== 2'b01 || d !== 16'd4 || timeout_o !== 1'b0) begin
            n_err++; $display("FAIL done_vs_expiry: got kind=%b data=%0d timeout=%b expected kind=01 data=4 timeout=0", k, d, timeout_o);
        end
        drive_job(2'b10, 32'h0000_0011, 1000, 1'b1, 8'h77, '0, 0, rc, gr, k, d, a, b, p, st, ra);
        tm_model = 1'b1;
        n_vec++;
        if (k !== 2'b10 || d !== '0 || timeout_o !== 1'b1 || rc !== TO) begin
            n_err++; $display("FAIL px_timeout: got kind=%b data=%h timeout=%b run=%0d expected kind=10 data=0000 timeout=1 run=%0d", k, d, timeout_o, rc, TO);
        end
    endtask

    task automatic test_nop();
        cmd_valid_i = 1'b1; cmd_op_i = 2'b00; cmd_data_i = $urandom;
        tick();
        cmd_valid_i = 1'b0;
        gcd_done_i = 1'b1; pixel_completed_i = 1'b1;
        tick();
        gcd_done_i = 1'b0; pixel_completed_i = 1'b0;
        tick();
        n_vec++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || timeout_o !== tm_model) begin
            n_err++; $display("FAIL nop_idle: got busy=%b ready=%b rsp=%b timeout=%b expected 0 1 0 %b",
                busy_o, cmd_ready_o, rsp_valid_o, timeout_o, tm_model);
        end
    endtask

    task automatic test_random();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        logic [1:0] op; logic [2*GW-1:0] data; int lat, stall; logic primed;
        logic [PW-1:0] sob; logic [GW-1:0] g, ea, eb; bit ok;
        logic [1:0] ek; logic [GW-1:0] ed;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                cmd_valid_i = 1'b1; cmd_op_i = 2'b11;
                tick();
                cmd_valid_i = 1'b0;
                tm_model = 1'b0;
            end
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            ea = GW'($urandom_range(0, 2000)); eb = GW'($urandom_range(0, 2000));
            data = (op == 2'b01) ? {ea, eb} : $urandom;
            lat = $urandom_range(1, TO + 4);
            stall = $urandom_range(0, 3);
            primed = 1'($urandom);
            sob = PW'($urandom);
            g = ref_gcd(ea, eb);
            drive_job(op, data, lat, primed, sob, g, stall, rc, gr, k, d, a, b, p, st, ra);
            ok = (lat <= TO);
            if (op == 2'b01) begin
                ek = {1'b0, ok};
                ed = ok ? g : '0;
            end else begin
                ek = {1'b1, ok & primed};
                ed = (ok && primed) ? GW'(sob) : '0;
            end
            if (!ok) tm_model = 1'b1;
            n_vec++;
            if (!gr || k !== ek || d !== ed || rc !== (ok ? lat : TO)) begin
                n_err++; $display("FAIL rand_rsp[%0d]: got kind=%b data=%h run=%0d expected kind=%b data=%h run=%0d",
                    i, k, d, rc, ek, ed, ok ? lat : TO);
            end
            n_vec++;
            if (op == 2'b01 ? (a !== ea || b !== eb) : (p !== data[PW-1:0])) begin
                n_err++; $display("FAIL rand_latch[%0d]: got a=%h b=%h px=%h expected a=%h b=%h px=%h",
                    i, a, b, p, ea, eb, data[PW-1:0]);
            end
            n_vec++;
            if (!st || !ra || timeout_o !== tm_model) begin
                n_err++; $display("FAIL rand_hs[%0d]: got stable=%0d ready=%0d timeout=%b expected 1 1 %b",
                    i, st, ra, timeout_o, tm_model);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int rc; bit gr, st, ra; logic [1:0] k; logic [GW-1:0] d, a, b; logic [PW-1:0] p;
        // Leave the sticky flag set so reset has something to clear
        drive_job(2'b01, {16'd9, 16'd6}, 1000, 1'b0, '0, 16'd3, 0, rc, gr, k, d, a, b, p, st, ra);
        cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_data_i = {16'd30, 16'd20};
        tick();
        cmd_valid_i = 1'b0;
        tick(); tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tm_model = 1'b0;
        n_vec++;
        if (gcd_enable_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || timeout_o !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_run: got en=%b rsp=%b ready=%b timeout=%b expected 0 0 1 0",
                gcd_enable_o, rsp_valid_o, cmd_ready_o, timeout_o);
        end
        gcd_done_i = 1'b1; gcd_i = 16'd10;
        tick();
        gcd_done_i = 1'b0;
        tick();
        n_vec++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL late_done: got rsp=%b busy=%b expected 0 0", rsp_valid_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_gcd_directed();
        test_pixel_directed();
        test_rsp_stall();
        test_timeout_clr();
        test_nop();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
